// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one 64-bit add/sub datapath among NUM_REQ slots,
// with a one-entry tagged response register. Define ADDSUB_ARB_OVF_EN to add rsp_ovf.
module addsub_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_op,
  input  logic [NUM_REQ*64-1:0] req_a,
  input  logic [NUM_REQ*64-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [63:0]           rsp_sum,
  output logic                  rsp_cout
`ifdef ADDSUB_ARB_OVF_EN
  ,
  output logic                  rsp_ovf
`endif
);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt, gnt_hi, gnt_lo, ptr_next;
  logic            found_hi, found_lo;
  logic            can_issue, accept;
  logic            sel_op;
  logic [63:0]     sel_a, sel_b, b_eff;
  logic [64:0]     full_sum;
`ifdef ADDSUB_ARB_OVF_EN
  logic            ovf;
`endif

  // Rotating priority: first valid slot at or above ptr, else lowest valid slot overall.
  always_comb begin
    gnt_hi   = '0;
    gnt_lo   = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (req_valid[j] && !found_lo) begin
        found_lo = 1'b1;
        gnt_lo   = ID_W'(j);
      end
      if (req_valid[j] && !found_hi && (j >= 32'(ptr))) begin
        found_hi = 1'b1;
        gnt_hi   = ID_W'(j);
      end
    end
    gnt = found_hi ? gnt_hi : gnt_lo;
  end

  assign can_issue = !rsp_valid || rsp_ready;
  assign accept    = rst_n && found_lo && can_issue;
  assign ptr_next  = (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + ID_W'(1);

  always_comb begin
    req_ready = '0;
    sel_op    = 1'b0;
    sel_a     = '0;
    sel_b     = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (gnt == ID_W'(j)) begin
        req_ready[j] = accept;
        sel_op       = req_op[j];
        sel_a        = req_a[j*64 +: 64];
        sel_b        = req_b[j*64 +: 64];
      end
    end
    b_eff    = sel_op ? ~sel_b : sel_b;
    full_sum = {1'b0, sel_a} + {1'b0, b_eff} + 65'(sel_op);
  end

`ifdef ADDSUB_ARB_OVF_EN
  assign ovf = (sel_a[63] == b_eff[63]) && (full_sum[63] != sel_a[63]);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      ptr       <= '0;
`ifdef ADDSUB_ARB_OVF_EN
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        rsp_id   <= gnt;
        rsp_sum  <= full_sum[63:0];
        rsp_cout <= full_sum[64];
        ptr      <= ptr_next;
`ifdef ADDSUB_ARB_OVF_EN
        rsp_ovf  <= ovf;
`endif
      end
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state     <= ST_FULL;
            rsp_valid <= 1'b1;
          end
        end
        ST_FULL: begin
          if (rsp_ready && !accept) begin
            state     <= ST_EMPTY;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed scenarios plus randomized traffic
// against a cycle-level behavioural model.
module tb_addsub_arbiter;

  localparam int NREQ = 4;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_op;
  logic [NREQ*64-1:0] req_a;
  logic [NREQ*64-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [63:0]       rsp_sum;
  logic              rsp_cout;
`ifdef ADDSUB_ARB_OVF_EN
  logic              rsp_ovf;
`endif

  logic [63:0] a_arr [NREQ];
  logic [63:0] b_arr [NREQ];

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic        m_valid;
  int          m_id;
  logic [63:0] m_sum;
  logic        m_cout;
  logic        m_ovf;
  int          m_ptr;

  addsub_arbiter #(.NUM_REQ(NREQ), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
`ifdef ADDSUB_ARB_OVF_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .rsp_cout  (rsp_cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*64 +: 64] = a_arr[i];
      req_b[i*64 +: 64] = b_arr[i];
    end
  end

  function automatic int pred_grant();
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    int g;
    logic [NREQ-1:0] r;
    r = '0;
    g = pred_grant();
    if (rst_n && g >= 0 && (!m_valid || rsp_ready)) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_edge();
    int g;
    logic [63:0] a, b;
    logic [64:0] u;
    logic signed [65:0] s;
    if (!rst_n) begin
      m_valid = 1'b0; m_id = 0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_ptr = 0;
    end else begin
      g = pred_grant();
      if (g >= 0 && (!m_valid || rsp_ready)) begin
        a = a_arr[g];
        b = b_arr[g];
        if (req_op[g]) begin
          m_sum  = a - b;
          m_cout = (a >= b);
          s = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
        end else begin
          u = {1'b0, a} + {1'b0, b};
          m_sum  = u[63:0];
          m_cout = u[64];
          s = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
        end
        m_ovf   = !(s[65:63] == 3'b000 || s[65:63] == 3'b111);
        m_id    = g;
        m_valid = 1'b1;
        m_ptr   = (g + 1) % NREQ;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '1; req_op = '0; rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin a_arr[i] = '0; b_arr[i] = '0; end
    #3;
    total++;
    if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    tick(); tick();
    total++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_sum !== 64'd0 || rsp_cout !== 1'b0) begin
      bad++; $display("FAIL reset_rsp got v=%b id=%0d sum=%h c=%b exp all zero", rsp_valid, rsp_id, rsp_sum, rsp_cout);
    end
    total++;
    if (dut.ptr !== 2'd0) begin bad++; $display("FAIL reset_ptr got=%0d exp=0", dut.ptr); end
    rst_n = 1'b1; req_valid = '0;
  endtask

  task automatic test_single_add();
    a_arr[2] = '1; b_arr[2] = 64'd1; req_op[2] = 1'b0; req_valid = 4'b0100; rsp_ready = 1'b1;
    #3;
    total++;
    if (req_ready !== 4'b0100) begin bad++; $display("FAIL add_ready got=%b exp=0100", req_ready); end
    tick();
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 64'd0 || rsp_cout !== 1'b1) begin
      bad++; $display("FAIL add_rsp got v=%b id=%0d sum=%h c=%b exp v=1 id=2 sum=0 c=1", rsp_valid, rsp_id, rsp_sum, rsp_cout);
    end
`ifdef ADDSUB_ARB_OVF_EN
    total++;
    if (rsp_ovf !== 1'b0) begin bad++; $display("FAIL add_ovf got=%b exp=0", rsp_ovf); end
`endif
    req_valid = '0;
  endtask

  task automatic test_subtract();
    a_arr[0] = 64'd5; b_arr[0] = 64'd7; req_op[0] = 1'b1; req_valid = 4'b0001;
    #3;
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL sub_ready got=%b exp=0001", req_ready); end
    tick();
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 64'hFFFF_FFFF_FFFF_FFFE || rsp_cout !== 1'b0) begin
      bad++; $display("FAIL sub_rsp got v=%b id=%0d sum=%h c=%b exp v=1 id=0 sum=fffffffffffffffe c=0", rsp_valid, rsp_id, rsp_sum, rsp_cout);
    end
`ifdef ADDSUB_ARB_OVF_EN
    a_arr[0] = 64'h8000_0000_0000_0000; b_arr[0] = 64'd1;
    tick();
    total++;
    if (rsp_ovf !== 1'b1 || rsp_sum !== 64'h7FFF_FFFF_FFFF_FFFF || rsp_cout !== 1'b1) begin
      bad++; $display("FAIL sub_ovf got ovf=%b sum=%h c=%b exp ovf=1 sum=7fffffffffffffff c=1", rsp_ovf, rsp_sum, rsp_cout);
    end
`endif
    req_valid = '0;
    tick();
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL sub_drain got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    int exp_a [6] = '{0, 1, 2, 3, 0, 1};
    int exp_b [4] = '{2, 3, 0, 2};
    rst_n = 1'b0; req_valid = '0;
    tick();
    rst_n = 1'b1; rsp_ready = 1'b1; req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin a_arr[i] = rnd64(); b_arr[i] = rnd64(); req_op[i] = 1'($urandom); end
    for (int k = 0; k < 10; k++) begin
      int e;
      logic [NREQ-1:0] er;
      if (k == 6) req_valid = 4'b1101;
      e = (k < 6) ? exp_a[k] : exp_b[k-6];
      er = '0; er[e] = 1'b1;
      #3;
      total++;
      if (req_ready !== er) begin bad++; $display("FAIL rr_ready step=%0d got=%b exp=%b", k, req_ready, er); end
      tick();
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(e) || rsp_sum !== m_sum) begin
        bad++; $display("FAIL rr_rsp step=%0d got v=%b id=%0d sum=%h exp v=1 id=%0d sum=%h", k, rsp_valid, rsp_id, rsp_sum, e, m_sum);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] s_sum;
    logic        s_cout;
    req_valid = 4'b1010; rsp_ready = 1'b1;
    tick();
    total++;
    if (rsp_id !== 2'd3 || rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_first got id=%0d v=%b exp id=3 v=1", rsp_id, rsp_valid); end
    s_sum = m_sum; s_cout = m_cout;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #3;
      total++;
      if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b exp=0000", k, req_ready); end
      tick();
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sum !== s_sum || rsp_cout !== s_cout) begin
        bad++; $display("FAIL bp_hold cyc=%0d got v=%b id=%0d sum=%h c=%b exp v=1 id=3 sum=%h c=%b", k, rsp_valid, rsp_id, rsp_sum, rsp_cout, s_sum, s_cout);
      end
      total++;
      if (dut.ptr !== 2'd0) begin bad++; $display("FAIL bp_ptr cyc=%0d got=%0d exp=0", k, dut.ptr); end
    end
    rsp_ready = 1'b1;
    #3;
    total++;
    if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_release_ready got=%b exp=0010", req_ready); end
    tick();
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== m_sum) begin
      bad++; $display("FAIL bp_nobubble got v=%b id=%0d sum=%h exp v=1 id=1 sum=%h", rsp_valid, rsp_id, rsp_sum, m_sum);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_stall();
    req_valid = 4'b0100; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; req_valid = 4'b1010;
    tick();
    rst_n = 1'b0;
    #3;
    total++;
    if (req_ready !== 4'b0000) begin bad++; $display("FAIL rststall_ready got=%b exp=0000", req_ready); end
    tick();
    total++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_sum !== 64'd0 || rsp_cout !== 1'b0 || dut.ptr !== 2'd0) begin
      bad++; $display("FAIL rststall_clear got v=%b id=%0d sum=%h c=%b ptr=%0d exp all zero", rsp_valid, rsp_id, rsp_sum, rsp_cout, dut.ptr);
    end
`ifdef ADDSUB_ARB_OVF_EN
    total++;
    if (rsp_ovf !== 1'b0) begin bad++; $display("FAIL rststall_ovf got=%b exp=0", rsp_ovf); end
`endif
    rst_n = 1'b1; rsp_ready = 1'b1;
    #3;
    total++;
    if (req_ready !== 4'b0010) begin bad++; $display("FAIL rststall_grant_ready got=%b exp=0010", req_ready); end
    tick();
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin bad++; $display("FAIL rststall_grant got v=%b id=%0d exp v=1 id=1", rsp_valid, rsp_id); end
    req_valid = '0;
  endtask

  task automatic test_idle();
    int p;
    req_valid = '0; rsp_ready = 1'b1;
    tick();
    p = m_ptr;
    for (int k = 0; k < 10; k++) begin
      #3;
      total++;
      if (req_ready !== 4'b0000) begin bad++; $display("FAIL idle_ready cyc=%0d got=%b exp=0000", k, req_ready); end
      tick();
      total++;
      if (rsp_valid !== 1'b0 || dut.ptr !== 2'(p)) begin
        bad++; $display("FAIL idle_state cyc=%0d got v=%b ptr=%0d exp v=0 ptr=%0d", k, rsp_valid, dut.ptr, p);
      end
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] acc;
    logic [NREQ-1:0] pend;
    acc = '0;
    for (int k = 0; k < 400; k++) begin
      pend = req_valid & ~acc;
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i]) begin
          req_valid[i] = ($urandom_range(0, 9) != 0);
        end else begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          req_op[i]    = 1'($urandom);
          a_arr[i]     = rnd64();
          b_arr[i]     = rnd64();
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #3;
      acc = exp_ready();
      total++;
      if (req_ready !== acc) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", k, req_ready, acc); end
      tick();
      total++;
      if (rsp_valid !== m_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", k, rsp_valid, m_valid); end
      if (m_valid) begin
        total++;
        if (rsp_id !== 2'(m_id) || rsp_sum !== m_sum || rsp_cout !== m_cout) begin
          bad++; $display("FAIL rnd_rsp cyc=%0d got id=%0d sum=%h c=%b exp id=%0d sum=%h c=%b", k, rsp_id, rsp_sum, rsp_cout, m_id, m_sum, m_cout);
        end
`ifdef ADDSUB_ARB_OVF_EN
        total++;
        if (rsp_ovf !== m_ovf) begin bad++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", k, rsp_ovf, m_ovf); end
`endif
      end
    end
    req_valid = '0;
  endtask

  initial begin
    m_valid = 1'b0; m_id = 0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_ptr = 0;
    test_reset();
    test_single_add();
    test_subtract();
    test_round_robin();
    test_backpressure();
    test_reset_stall();
    test_idle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Shares one 64-bit add/subtract datapath among `NUM_REQ` VLIW issue slots. Each slot presents operands through a valid/ready handshake. A round-robin arbiter issues at most one operation per cycle into the shared adder. The result is captured in a one-entry output register and returned on a single tagged response channel with backpressure. The block sits between the issue stage and writeback, and is the only path by which slots reach the ADD/SUB datapath.

## Interface
- `NUM_REQ`, default 4: number of requesting slots, 2..8.
- `ID_W`, default 2: width of `rsp_id`; must satisfy 2^`ID_W` >= `NUM_REQ`.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset is synchronous and active-low.
- `req_valid` input `NUM_REQ`: bit i means slot i has an operation pending.
- `req_ready` output `NUM_REQ`: bit i means slot i's operation is accepted this cycle.
- `req_op` input `NUM_REQ`: per-slot operation; 0 = add, 1 = subtract.
- `req_a` input `NUM_REQ`*64: slot i operand A occupies bits [64i+63:64i].
- `req_b` input `NUM_REQ`*64: slot i operand B, same packing as `req_a`.
- `rsp_valid` output 1: the output register holds a result.
- `rsp_ready` input 1: the consumer accepts the result.
- `rsp_id` output `ID_W`: index of the slot that issued the result.
- `rsp_sum` output 64: result value.
- `rsp_cout` output 1: carry out of bit 63. For subtract, 1 means no borrow.
- `rsp_ovf` output 1: signed overflow. Present only with `ADDSUB_ARB_OVF_EN`.

## Operation
- Arithmetic:
  - add: {cout,sum} = A + B.
  - subtract: {cout,sum} = A + ~B + 1.
  - Both are 65-bit; sum takes the low 64 bits and wraps modulo 2^64.
- Issue enable: `can_issue` = !`rsp_valid` | `rsp_ready`.
- Arbitration:
  - Round-robin pointer `ptr`, range 0..`NUM_REQ`-1.
  - Search `req_valid` starting at `ptr`, ascending with wrap.
  - The first set bit is the grant `g`.
  - `req_ready[g]` = `can_issue`; all other `req_ready` bits are 0.
  - If no bit of `req_valid` is set, all `req_ready` bits are 0.
  - `req_ready` may depend combinationally on `req_valid` and `rsp_ready`.
- Accept: on a cycle where `req_valid[g]` & `req_ready[g]` is true:
  - The adder result for slot g is loaded into `rsp_sum`/`rsp_cout`/`rsp_ovf`.
  - `rsp_id` is loaded with g.
  - `rsp_valid` is set to 1.
  - `ptr` becomes (g+1) mod `NUM_REQ`.
- Output register FSM:
  - EMPTY (`rsp_valid`=0): accept goes to FULL; no request stays EMPTY.
  - FULL (`rsp_valid`=1) with `rsp_ready`=1 and an accept: reload, stay FULL.
  - FULL with `rsp_ready`=1 and no accept: go to EMPTY.
  - FULL with `rsp_ready`=0: hold all response fields; `req_ready` is all 0; `ptr` holds.
- Requesters must hold `req_op`, `req_a` and `req_b` stable while `req_valid` is high and not yet accepted. The block does not latch an operation before acceptance.
- Deasserting `req_valid` without acceptance is permitted and leaves no residual state.

## Timing
- Latency: an operation accepted at edge N presents `rsp_valid`=1 with its result after edge N. One cycle of latency.
- Throughput: one operation per cycle while `rsp_ready` is held at 1.
- While stalled, `rsp_*` outputs are stable until the edge where `rsp_valid` & `rsp_ready`.
- Reset (`rst_n`=0 at an edge), regardless of state or in-flight handshakes:
  - `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_cout`=0, `rsp_ovf`=0, `ptr`=0.
  - During a reset cycle, `req_ready` is forced to 0.
  - A pending response is discarded, not delivered.
- Boundary cases:
  - Simultaneous drain and accept in FULL: no bubble.
  - `ptr` at `NUM_REQ`-1 with grant to slot `NUM_REQ`-1 wraps to 0.
  - A single active slot is granted every cycle.
  - `rsp_id` values at or above `NUM_REQ` never occur.

## Configuration
- `ADDSUB_ARB_OVF_EN` defined:
  - Adds the `rsp_ovf` port.
  - `rsp_ovf` = (A63 == B'63) & (sum63 != A63), where B' = B for add and ~B for subtract.
  - `rsp_ovf` is registered with the other response fields.
- `ADDSUB_ARB_OVF_EN` not defined: the `rsp_ovf` port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset then single add:
  - Stimulus: slot 2 requests add with A=0xFFFFFFFFFFFFFFFF, B=1; `rsp_ready`=1.
  - Response: next cycle `rsp_valid`=1, `rsp_id`=2, `rsp_sum`=0, `rsp_cout`=1, `rsp_ovf`=0.
- Subtract:
  - Stimulus: slot 0 requests subtract with A=5, B=7.
  - Response: `rsp_sum`=0xFFFFFFFFFFFFFFFE, `rsp_cout`=0. With the macro, also A=0x8000000000000000, B=1 gives `rsp_ovf`=1.
- Round-robin:
  - Stimulus: all 4 slots hold `req_valid` from reset with `rsp_ready`=1.
  - Response: grant order 0,1,2,3,0,1.
  - Then drop slot 1: order continues 2,3,0,2.
- Backpressure:
  - Stimulus: `rsp_ready`=0 for 3 cycles while FULL and slots 1 and 3 are valid.
  - Response: `rsp_*` fields are stable, `req_ready`=0, `ptr` unchanged.
  - On `rsp_ready`=1, the drain and the next grant occur in the same cycle with no bubble.
- Reset mid-stall:
  - Stimulus: `rst_n`=0 while FULL and stalled.
  - Response: `rsp_valid`=0 and all response fields are 0 after that edge. The first post-reset grant goes to the lowest valid slot.
- Idle:
  - Stimulus: no `req_valid` for 10 cycles.
  - Response: `rsp_valid` stays 0 and `ptr` is unchanged.
